// File: rtl/sipo_deserializer_if.sv
// Bus interface for the SIPO deserializer.
// Groups the serial input (si, si_valid, clear) and the parallel output side
// (dout, dout_valid, dout_ready, overrun, bit_cnt).
//   master : the producer/consumer environment (drives si, si_valid, clear, dout_ready)
//   slave  : the deserializer itself (drives dout, dout_valid, overrun, bit_cnt)
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic            si;
    logic            si_valid;
    logic            clear;
    logic [WIDTH-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            overrun;
    logic [CW-1:0]   bit_cnt;

    modport master (
        output si, si_valid, clear, dout_ready,
        input  dout, dout_valid, overrun, bit_cnt
    );

    modport slave (
        input  si, si_valid, clear, dout_ready,
        output dout, dout_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer (receive end of the PISO serial link).
// Collects WIDTH valid-qualified serial bits into a word, presents each
// completed word in a holding register with a valid/ready handshake, and
// raises a sticky overrun flag when a completed word has to be dropped.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sipo_deserializer_if slave modport
//          si/si_valid  serial bit and its qualifier
//          clear        synchronous framing reset (drops partial word, clears overrun)
//          dout/dout_valid/dout_ready  output word handshake
//          overrun      sticky dropped-word flag
//          bit_cnt      bits of the current partial word received so far
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst,
    sipo_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_n_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] dout_r;
    logic             overrun_r;
    logic             accept_s;
    logic             complete_s;
    logic             load_s;
    logic             ovr_evt_s;

    // A bit taken on a clear edge is discarded, so it can never complete a word.
    assign accept_s   = bus.si_valid & ~bus.clear;
    assign complete_s = accept_s & (bit_cnt_r == CW'(WIDTH - 1));

    // Shift register value after taking in the current si bit.
    always_comb begin
        shifted_s = shreg_r;
        if (LSB_FIRST) begin
            shifted_s = {bus.si, shreg_r[WIDTH-1:1]};
        end else begin
            shifted_s = {shreg_r[WIDTH-2:0], bus.si};
        end
    end

    // Input shift register and partial-word bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (bus.clear) begin
            shreg_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            shreg_r   <= shifted_s;
            bit_cnt_r <= complete_s ? {CW{1'b0}} : bit_cnt_r + CW'(1);
        end
    end

    // Output FSM next state, holding-register load and overrun event.
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        ovr_evt_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (complete_s) begin
                    state_n_s = FULL;
                    load_s    = 1'b1;
                end else begin
                    state_n_s = EMPTY;
                end
            end
            FULL: begin
                if (complete_s && bus.dout_ready) begin
                    // Consumer takes the old word while the new one lands: no bubble.
                    state_n_s = FULL;
                    load_s    = 1'b1;
                end else if (complete_s) begin
                    state_n_s = FULL;
                    ovr_evt_s = 1'b1;
                end else if (bus.dout_ready) begin
                    state_n_s = EMPTY;
                end else begin
                    state_n_s = FULL;
                end
            end
            default: begin
                state_n_s = EMPTY;
            end
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Holding register; only rewritten by a load, so it is stable while FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            dout_r <= shifted_s;
        end
    end

    // Sticky overrun flag; clear takes priority over a same-edge event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (bus.clear) begin
            overrun_r <= 1'b0;
        end else if (ovr_evt_s) begin
            overrun_r <= 1'b1;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = (state_r == FULL);
    assign bus.overrun    = overrun_r;
    assign bus.bit_cnt    = bit_cnt_r;
endmodule
